ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit with a prefetch buffer. It issues pipelined fetch requests to instruction memory and keeps several requests in flight. Returned instructions are buffered with their PCs in an in-order FIFO and presented to the decoder through a valid/ready handshake. Exception and branch redirects flush the buffer and discard stale in-flight responses. It sits between the instruction memory port and idu, and replaces the single-register PC fetch stage.

---
 rtl/ifu_prefetch.sv | 156 +++++++++++++++
 tb/tb_ifu_prefetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch
// Purpose  : Pipelined instruction prefetch with in-order PC/instruction FIFO
//            and redirect flush that drops stale in-flight responses.
// Revision : 1.0
// ============================================================================
module ifu_prefetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
    parameter int              DEPTH      = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_inst_o,
    input  logic            if_ready_i,
    input  logic            jump_req_i,
    input  logic [XLEN-1:0] jump_pc_i,
    input  logic            excp_jump_req_i,
    input  logic [XLEN-1:0] excp_jump_pc_i
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W:0]   c_DEPTH_OCC = (c_CNT_W+1)'(DEPTH);
    localparam logic [XLEN-1:0]    c_PC_STEP   = XLEN'(4);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_resp_pc;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [XLEN-1:0]    r_fifo_pc   [DEPTH];
    logic [XLEN-1:0]    r_fifo_inst [DEPTH];

    logic               w_redir;
    logic [XLEN-1:0]    w_target_raw;
    logic [XLEN-1:0]    w_target;
    logic [c_CNT_W:0]   w_occ;
    logic               w_credit;
    logic               w_grant;
    logic               w_dropping;
    logic               w_push;
    logic               w_pop;
    logic               w_nonempty;
    logic [c_CNT_W-1:0] w_rvalid_cnt;

    assign w_redir      = excp_jump_req_i | jump_req_i;
    assign w_target_raw = excp_jump_req_i ? excp_jump_pc_i : jump_pc_i;
    assign w_target     = {w_target_raw[XLEN-1:2], 2'b00};

    // Credit covers in-flight requests (including ones that will be dropped)
    // plus buffered entries, so every accepted response always has a slot.
    assign w_occ      = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_credit   = (w_occ < c_DEPTH_OCC);

    assign mem_req_o  = !rst && !w_redir && w_credit;
    assign mem_addr_o = r_fetch_pc;
    assign w_grant    = mem_req_o && mem_gnt_i;

    assign w_nonempty   = (r_count != '0);
    assign w_dropping   = (r_drop_cnt != '0);
    assign w_push       = mem_rvalid_i && !w_dropping && !w_redir;
    assign w_pop        = w_nonempty && if_ready_i && !w_redir;
    assign w_rvalid_cnt = {{(c_CNT_W-1){1'b0}}, mem_rvalid_i};

    assign if_valid_o = !rst && w_nonempty;
    assign if_pc_o    = if_valid_o ? r_fifo_pc[r_rptr]   : '0;
    assign if_inst_o  = if_valid_o ? r_fifo_inst[r_rptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_ADDR;
            r_resp_pc  <= RESET_ADDR;
        end else if (w_redir) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + c_PC_STEP;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + c_PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_grant, mem_rvalid_i})
                2'b10:   r_inflight <= r_inflight + c_CNT_ONE;
                2'b01:   r_inflight <= r_inflight - c_CNT_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // A response arriving in the redirect cycle is discarded directly,
    // so it is excluded from the count of stale responses still to come.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_redir) begin
            r_drop_cnt <= r_inflight - w_rvalid_cnt;
        end else if (mem_rvalid_i && w_dropping) begin
            r_drop_cnt <= r_drop_cnt - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_redir) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]   <= r_resp_pc;
            r_fifo_inst[r_wptr] <= mem_rdata_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_prefetch
// Purpose  : Directed bench for ifu_prefetch with a latency-configurable memory.
// Revision : 1.0
// ============================================================================
module tb_ifu_prefetch;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] c_XOR = 32'hA5A5_A5A5;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            if_valid_o;
    logic [XLEN-1:0] if_pc_o;
    logic [XLEN-1:0] if_inst_o;
    logic            if_ready_i;
    logic            jump_req_i;
    logic [XLEN-1:0] jump_pc_i;
    logic            excp_jump_req_i;
    logic [XLEN-1:0] excp_jump_pc_i;

    ifu_prefetch #(
        .XLEN       (XLEN),
        .RESET_ADDR (32'h0000_0000),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_ready_i      (if_ready_i),
        .jump_req_i      (jump_req_i),
        .jump_pc_i       (jump_pc_i),
        .excp_jump_req_i (excp_jump_req_i),
        .excp_jump_pc_i  (excp_jump_pc_i)
    );

    always #5 clk = ~clk;

    int          checks     = 0;
    int          failures   = 0;
    int          cyc        = 0;
    int          lat        = 1;
    int          first_valid = -1;
    int          rel        = 0;
    int          found      = 0;
    logic        req_in_rst = 1'b0;
    logic [31:0] exp_next   = '0;
    logic [31:0] head_pc    = '0;
    logic [31:0] rq_addr [$];
    int          rq_due  [$];
    logic [31:0] dv_pc   [$];
    logic [31:0] dv_inst [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: memory responds from its in-order queue, grants and
    // accepted instructions are recorded, then advance to the next negedge.
    task automatic cycle();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (!rst && rq_due.size() > 0 && rq_due[0] <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rq_addr[0] ^ c_XOR;
            void'(rq_addr.pop_front());
            void'(rq_due.pop_front());
        end
        #1;
        if (rst && mem_req_o) req_in_rst = 1'b1;
        if (!rst && if_valid_o && first_valid < 0) first_valid = cyc;
        if (mem_req_o && mem_gnt_i) begin
            rq_addr.push_back(mem_addr_o);
            rq_due.push_back(cyc + lat);
        end
        if (if_valid_o && if_ready_i && !(jump_req_i || excp_jump_req_i)) begin
            dv_pc.push_back(if_pc_o);
            dv_inst.push_back(if_inst_o);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_stream(input string tag, input int exp_n);
        if (exp_n >= 0) chk({tag, "_count"}, dv_pc.size(), exp_n);
        chk({tag, "_nonempty"}, {31'd0, dv_pc.size() > 0}, 32'd1);
        while (dv_pc.size() > 0) begin
            chk({tag, "_pc"}, dv_pc[0], exp_next);
            chk({tag, "_inst"}, dv_inst[0], exp_next ^ c_XOR);
            void'(dv_pc.pop_front());
            void'(dv_inst.pop_front());
            exp_next = exp_next + 32'd4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        if_ready_i = 1'b1; jump_req_i = 1'b0; jump_pc_i = '0;
        excp_jump_req_i = 1'b0; excp_jump_pc_i = '0;
        @(negedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
        chk("rst_pc", if_pc_o, 32'd0);
        chk("rst_inst", if_inst_o, 32'd0);
        run(3);

        // Test 1: zero-wait streaming from reset address
        rst = 1'b0; rel = cyc; first_valid = -1;
        run(12);
        chk("t1_req_in_rst", {31'd0, req_in_rst}, 32'd0);
        chk("t1_first_latency", first_valid - rel, 32'd2);
        exp_next = 32'h0;
        check_stream("t1", 10);
        mem_gnt_i = 1'b0;
        run(3);
        mem_gnt_i = 1'b1;
        run(6);
        check_stream("t1_gnt", -1);

        // Test 2: decoder stall fills the buffer, then drains in order
        if_ready_i = 1'b0; head_pc = exp_next;
        run(10);
        #1;
        chk("t2_req_low", {31'd0, mem_req_o}, 32'd0);
        chk("t2_valid", {31'd0, if_valid_o}, 32'd1);
        chk("t2_head_pc", if_pc_o, head_pc);
        chk("t2_fetch_addr", mem_addr_o, head_pc + 32'h10);
        chk("t2_outstanding", rq_due.size(), 32'd0);
        if_ready_i = 1'b1;
        run(10);
        check_stream("t2", 10);

        // Test 3: branch with three requests in flight at latency 3
        lat = 3; found = 0;
        for (int i = 0; i < 20; i++) begin
            if (rq_due.size() == 3) begin found = 1; break; end
            cycle();
        end
        chk("t3_three_inflight", found, 32'd1);
        check_stream("t3_pre", -1);
        jump_req_i = 1'b1; jump_pc_i = 32'h100;
        #1;
        chk("t3_req_on_redir", {31'd0, mem_req_o}, 32'd0);
        cycle();
        jump_req_i = 1'b0;
        run(15);
        exp_next = 32'h100;
        check_stream("t3", -1);

        // Test 4: exception wins over branch; same-cycle response dropped
        lat = 1;
        run(6);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (rq_due.size() > 0 && rq_due[0] <= cyc) begin found = 1; break; end
            cycle();
        end
        chk("t4_resp_same_cycle", found, 32'd1);
        check_stream("t4_pre", -1);
        excp_jump_req_i = 1'b1; excp_jump_pc_i = 32'h800;
        jump_req_i = 1'b1; jump_pc_i = 32'h100;
        cycle();
        excp_jump_req_i = 1'b0; jump_req_i = 1'b0;
        run(10);
        exp_next = 32'h800;
        check_stream("t4", -1);

        // Test 5: misaligned target is word aligned
        jump_req_i = 1'b1; jump_pc_i = 32'h103;
        cycle();
        jump_req_i = 1'b0;
        #1;
        chk("t5_fetch_addr", mem_addr_o, 32'h100);
        run(8);
        exp_next = 32'h100;
        check_stream("t5", -1);

        // Test 6: reset with two in flight and two buffered
        if_ready_i = 1'b0;
        run(8);
        chk("t6_drained", rq_due.size(), 32'd0);
        lat = 3;
        jump_req_i = 1'b1; jump_pc_i = 32'h200;
        cycle();
        jump_req_i = 1'b0;
        run(5);
        #1;
        chk("t6_inflight", rq_due.size(), 32'd2);
        chk("t6_valid", {31'd0, if_valid_o}, 32'd1);
        chk("t6_head_pc", if_pc_o, 32'h200);
        chk("t6_head_inst", if_inst_o, 32'h200 ^ c_XOR);
        chk("t6_fetch_addr", mem_addr_o, 32'h210);
        chk("t6_req_full", {31'd0, mem_req_o}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("t6_rst_valid", {31'd0, if_valid_o}, 32'd0);
        chk("t6_rst_pc", if_pc_o, 32'd0);
        chk("t6_rst_inst", if_inst_o, 32'd0);
        rq_addr.delete(); rq_due.delete();
        if_ready_i = 1'b1; lat = 1;
        run(2);
        rst = 1'b0; rel = cyc; first_valid = -1;
        run(8);
        chk("t6_req_in_rst", {31'd0, req_in_rst}, 32'd0);
        chk("t6_first_latency", first_valid - rel, 32'd2);
        exp_next = 32'h0;
        check_stream("t6", 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
